// File: rtl/reg_write_queue_pkg.sv
// Shared CPU constants and the queued register-write entry type.
package reg_write_queue_pkg;

    localparam int REG_W  = 4;
    localparam int DATA_W = 16;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // A request only matters if it is valid and does not target R0.
    function automatic logic is_live(input logic valid, input logic [REG_W-1:0] dst);
        return valid && (dst != ZERO_REG);
    endfunction

endpackage

// File: rtl/reg_write_queue_entry_match.sv
// Compares one queued write entry against one decode-stage source register.
module reg_write_entry_match
    import reg_write_queue_pkg::*;
(
    input  logic             valid,
    input  logic [REG_W-1:0] entry_dst,
    input  logic [REG_W-1:0] src,
    output logic             hit
);

    assign hit = valid && (src != ZERO_REG) && (entry_dst == src);

endmodule

// File: rtl/reg_write_queue.sv
// Ordered queue of pending register-file writes (Mem before Alu), drained one per cycle,
// with a youngest-match lookup for the decode stage.
module reg_write_queue
    import reg_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemValid,
    input  logic [REG_W-1:0]  MemDst,
    input  logic [DATA_W-1:0] MemData,
    input  logic              AluValid,
    input  logic [REG_W-1:0]  AluDst,
    input  logic [DATA_W-1:0] AluData,
    output logic              Full,
    output logic              WriteReg,
    output logic [REG_W-1:0]  DstReg,
    output logic [DATA_W-1:0] DstData,
    input  logic [REG_W-1:0]  SrcReg1,
    input  logic [REG_W-1:0]  SrcReg2,
    output logic              Hit1,
    output logic              Hit2,
    output logic [DATA_W-1:0] PendData1,
    output logic [DATA_W-1:0] PendData2,
    output logic              Overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_AT = CW'(DEPTH - 1);

    wr_entry_t        store [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    tail_p1;
    logic [PW-1:0]    head_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    remain;
    logic             mem_live;
    logic             alu_live;
    logic             mem_ok;
    logic             alu_ok;
    logic             deq;
    logic [1:0]       n_enq;
    wr_entry_t        mem_ent;
    wr_entry_t        alu_ent;
    wr_entry_t        ent_n;
    logic             wr_n;
    logic [DEPTH-1:0] valid_slot;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    assign Full      = count >= FULL_AT;
    assign mem_live  = is_live(MemValid, MemDst);
    assign alu_live  = is_live(AluValid, AluDst);
    assign mem_ok    = mem_live && !Full;
    assign alu_ok    = alu_live && !Full;
    assign mem_ent   = '{dst: MemDst, data: MemData};
    assign alu_ent   = '{dst: AluDst, data: AluData};
    assign deq       = count != '0;
    assign n_enq     = {1'b0, mem_ok} + {1'b0, alu_ok};
    assign head_next = head + PW'(deq);
    assign tail_p1   = tail + PW'(1);
    assign remain    = count - CW'(deq);

    // The write-port registers always mirror the head that will exist after this edge,
    // bypassing an incoming request straight through when nothing older remains.
    always_comb begin
        wr_n  = 1'b0;
        ent_n = '0;
        if (remain != '0) begin
            wr_n  = 1'b1;
            ent_n = store[head_next];
        end else if (mem_ok) begin
            wr_n  = 1'b1;
            ent_n = mem_ent;
        end else if (alu_ok) begin
            wr_n  = 1'b1;
            ent_n = alu_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            Overflow <= 1'b0;
            WriteReg <= 1'b0;
            DstReg   <= '0;
            DstData  <= '0;
        end else begin
            head     <= head_next;
            tail     <= tail + PW'(n_enq);
            count    <= remain + CW'(n_enq);
            if ((mem_live || alu_live) && Full)
                Overflow <= 1'b1;
            WriteReg <= wr_n;
            DstReg   <= ent_n.dst;
            DstData  <= ent_n.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (mem_ok)
                store[tail] <= mem_ent;
            if (alu_ok)
                store[mem_ok ? tail_p1 : tail] <= alu_ent;
        end
    end

    // A slot is live when its age offset from head is below the occupancy.
    always_comb begin
        valid_slot = '0;
        for (int i = 0; i < DEPTH; i++)
            valid_slot[i] = {1'b0, PW'(i) - head} < count;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        reg_write_entry_match u_match1 (
            .valid     (valid_slot[g]),
            .entry_dst (store[g].dst),
            .src       (SrcReg1),
            .hit       (match1[g])
        );
        reg_write_entry_match u_match2 (
            .valid     (valid_slot[g]),
            .entry_dst (store[g].dst),
            .src       (SrcReg2),
            .hit       (match2[g])
        );
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] slot;
        slot      = '0;
        Hit1      = 1'b0;
        Hit2      = 1'b0;
        PendData1 = '0;
        PendData2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (match1[slot]) begin
                Hit1      = 1'b1;
                PendData1 = store[slot].data;
            end
            if (match2[slot]) begin
                Hit2      = 1'b1;
                PendData2 = store[slot].data;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed and randomized checks of reg_write_queue against a queue-based reference model.
module tb_reg_write_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  dst;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemValid = 1'b0;
    logic [3:0]  MemDst = '0;
    logic [15:0] MemData = '0;
    logic        AluValid = 1'b0;
    logic [3:0]  AluDst = '0;
    logic [15:0] AluData = '0;
    logic [3:0]  SrcReg1 = '0;
    logic [3:0]  SrcReg2 = '0;
    logic        Full, WriteReg, Hit1, Hit2, Overflow;
    logic [3:0]  DstReg;
    logic [15:0] DstData, PendData1, PendData2;

    int   total = 0;
    int   bad = 0;
    bit   chk_en = 0;
    bit   watch_r5 = 0;
    bit   seen_r5 = 0;
    ent_t mq[$];
    bit   m_ovf = 0;
    bit   m_full;

    reg_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .MemValid(MemValid), .MemDst(MemDst), .MemData(MemData),
        .AluValid(AluValid), .AluDst(AluDst), .AluData(AluData),
        .Full(Full), .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .Hit1(Hit1), .Hit2(Hit2), .PendData1(PendData1), .PendData2(PendData2),
        .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the queue holds everything not yet written, head is on the write port.
    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            m_full = (DEPTH - mq.size()) < 2;
            if (mq.size() > 0) void'(mq.pop_front());
            if (MemValid && MemDst != 0) begin
                if (m_full) m_ovf = 1;
                else mq.push_back('{dst: MemDst, data: MemData});
            end
            if (AluValid && AluDst != 0) begin
                if (m_full) m_ovf = 1;
                else mq.push_back('{dst: AluDst, data: AluData});
            end
        end
    end

    function automatic void m_lookup(input logic [3:0] src, output logic hit, output logic [15:0] d);
        hit = 0;
        d = '0;
        if (src != 0)
            foreach (mq[i])
                if (mq[i].dst == src) begin
                    hit = 1;
                    d = mq[i].data;
                end
    endfunction

    always @(negedge clk) begin
        logic        e_hit1, e_hit2;
        logic [15:0] e_pd1, e_pd2;
        if (chk_en) begin
            m_lookup(SrcReg1, e_hit1, e_pd1);
            m_lookup(SrcReg2, e_hit2, e_pd2);
            chk("pc_writereg", 32'(WriteReg), 32'(mq.size() > 0));
            chk("pc_dstreg", 32'(DstReg), mq.size() > 0 ? 32'(mq[0].dst) : 32'd0);
            chk("pc_dstdata", 32'(DstData), mq.size() > 0 ? 32'(mq[0].data) : 32'd0);
            chk("pc_full", 32'(Full), 32'((DEPTH - mq.size()) < 2));
            chk("pc_overflow", 32'(Overflow), 32'(m_ovf));
            chk("pc_hit1", 32'(Hit1), 32'(e_hit1));
            chk("pc_pend1", 32'(PendData1), 32'(e_pd1));
            chk("pc_hit2", 32'(Hit2), 32'(e_hit2));
            chk("pc_pend2", 32'(PendData2), 32'(e_pd2));
        end
        if (watch_r5 && WriteReg && DstReg == 4'd5) seen_r5 = 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                         input logic av, input logic [3:0] ad, input logic [15:0] adat);
        MemValid = mv; MemDst = md; MemData = mdat;
        AluValid = av; AluDst = ad; AluData = adat;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 0;
        repeat (2) cyc();
        rst = 1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_writereg", 32'(WriteReg), 0);
        chk("rst_dstreg", 32'(DstReg), 0);
        chk("rst_full", 32'(Full), 0);
        chk("rst_overflow", 32'(Overflow), 0);

        // single Mem write, one cycle latency
        drive(1, 4'd1, 16'h0101, 0, 0, 0);
        cyc(); idle();
        @(negedge clk);
        chk("t1_wr", 32'(WriteReg), 1);
        chk("t1_dst", 32'(DstReg), 1);
        chk("t1_data", 32'(DstData), 32'h0101);
        cyc(); @(negedge clk);
        chk("t1_idle", 32'(WriteReg), 0);

        // Mem and Alu same cycle: Mem first
        drive(1, 4'd2, 16'h1010, 1, 4'd3, 16'h00aa);
        cyc(); idle();
        @(negedge clk);
        chk("t2_dst_a", 32'(DstReg), 2);
        chk("t2_data_a", 32'(DstData), 32'h1010);
        cyc(); @(negedge clk);
        chk("t2_dst_b", 32'(DstReg), 3);
        chk("t2_data_b", 32'(DstData), 32'h00aa);
        cyc(); @(negedge clk);
        chk("t2_idle", 32'(WriteReg), 0);

        // R0 write discarded
        SrcReg1 = 0;
        drive(0, 0, 0, 1, 4'd0, 16'hbbcc);
        cyc(); idle();
        @(negedge clk);
        chk("t3_wr", 32'(WriteReg), 0);
        chk("t3_hit", 32'(Hit1), 0);

        // fill to DEPTH-1, then an extra request is dropped
        drive(1, 4'd6, 16'h0606, 1, 4'd7, 16'h0707);
        cyc();
        drive(1, 4'd9, 16'h0909, 1, 4'd10, 16'h0a0a);
        cyc(); idle();
        @(negedge clk);
        chk("t4_full", 32'(Full), 1);
        watch_r5 = 1;
        drive(0, 0, 0, 1, 4'd5, 16'h1234);
        cyc(); idle();
        @(negedge clk);
        chk("t4_overflow", 32'(Overflow), 1);
        repeat (6) cyc();
        @(negedge clk);
        watch_r5 = 0;
        chk("t4_no_r5", 32'(seen_r5), 0);

        // youngest match wins, including the entry on the write port
        SrcReg1 = 4'd8;
        drive(1, 4'd8, 16'h1111, 1, 4'd8, 16'habcd);
        cyc(); idle();
        @(negedge clk);
        chk("t5_data_a", 32'(DstData), 32'h1111);
        chk("t5_hit_a", 32'(Hit1), 1);
        chk("t5_pend_a", 32'(PendData1), 32'habcd);
        cyc(); @(negedge clk);
        chk("t5_data_b", 32'(DstData), 32'habcd);
        chk("t5_hit_b", 32'(Hit1), 1);
        chk("t5_pend_b", 32'(PendData1), 32'habcd);
        cyc(); @(negedge clk);
        chk("t5_hit_c", 32'(Hit1), 0);
        chk("t5_pend_c", 32'(PendData1), 0);

        // reset with three entries queued
        drive(1, 4'd11, 16'h0b0b, 1, 4'd12, 16'h0c0c);
        cyc();
        drive(1, 4'd13, 16'h0d0d, 1, 4'd14, 16'h0e0e);
        cyc();
        drive(1, 4'd15, 16'h0f0f, 0, 0, 0);
        rst = 0;
        cyc();
        rst = 1; idle();
        @(negedge clk);
        chk("t6_wr", 32'(WriteReg), 0);
        chk("t6_full", 32'(Full), 0);
        chk("t6_overflow", 32'(Overflow), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); @(negedge clk);
            chk("t6_no_stale", 32'(WriteReg), 0);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom));
            SrcReg1 = 4'($urandom_range(0, 7));
            SrcReg2 = 4'($urandom_range(0, 7));
            rst = ($urandom_range(0, 59) != 0);
            cyc();
        end
        rst = 1; idle();
        repeat (6) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4; number of queued register writes (power of two, at least 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports MemValid  input  1, MemDst  input  4, MemData  input  16; load-result write request (older instruction).
REQ-005 SHALL have ports AluValid  input  1, AluDst  input  4, AluData  input  16; ALU-result write request (younger instruction).
REQ-006 SHALL have port Full  output  1  asserted when fewer than 2 entries are free; producers must hold requests.
REQ-007 SHALL have ports WriteReg  output  1, DstReg  output  4, DstData  output  16; register file write port.
REQ-008 SHALL have ports SrcReg1, SrcReg2  input  4 each; decode-stage lookup addresses.
REQ-009 SHALL have ports Hit1, Hit2  output  1 and PendData1, PendData2  output  16; pending-write lookup results.
REQ-010 SHALL have port Overflow  output  1  sticky error flag.

Function
REQ-011 SHALL enqueue requests in program order: Mem before Alu when both are valid in the same cycle.
REQ-012 SHALL discard any request with Dst = 0 without enqueueing it; R0 is never written.
REQ-013 SHALL drain the oldest entry each cycle the queue is non-empty: WriteReg=1, DstReg/DstData from the head entry, registered outputs.
REQ-014 SHALL have 1-cycle latency: a request accepted at edge N is presented on the write port during cycle N+1 when the queue was empty.
REQ-015 SHALL hold WriteReg=0 and DstReg/DstData=0 while empty.
REQ-016 SHALL perform enqueue (0, 1 or 2 entries) and drain (0 or 1 entry) in the same cycle; occupancy = old + enq - deq.
REQ-017 SHALL wrap head and tail pointers modulo DEPTH; the count register is DEPTH-range plus one bit.
REQ-018 SHALL compute Full combinationally from occupancy: Full = (DEPTH - count) < 2.
REQ-019 SHALL, if a valid nonzero request arrives while Full=1, drop that request and set Overflow; Overflow clears only on reset.
REQ-020 SHALL compute Hit/PendData combinationally over queued entries (excluding the entry currently on the write port) plus the entry currently on the write port; the youngest match wins.
REQ-021 SHALL force Hit=0 and PendData=0 for SrcReg = 0 or no match.
REQ-022 SHALL exclude same-cycle incoming requests from lookup.

Reset
REQ-023 SHALL, when rst=0 at a rising edge, clear count, pointers and Overflow, and set WriteReg=0, DstReg=0, DstData=0.
REQ-024 SHALL discard in-flight queue contents on reset mid-operation; requests presented during reset are ignored.
REQ-025 SHALL leave entry storage uninitialised on reset; validity comes from pointers and count only.

Structure
REQ-026 SHALL place the register-address width (4), data width (16) and zero-register index in the shared CPU package.
REQ-027 SHALL use one sub-module, reg_write_entry_match, comparing one entry against one SrcReg; instantiated per entry per lookup port.
REQ-028 SHALL connect WriteReg/DstReg/DstData directly to the register file write port with no glue logic.

Verification
REQ-029 SHALL check: reset, then Mem(R1,0x0101) -> next cycle WriteReg=1, DstReg=1, DstData=0x0101; following cycle WriteReg=0.
REQ-030 SHALL check: Mem(R2,0x1010) with Alu(R3,0x00aa) in the same cycle -> R2 written, then R3 written the next cycle.
REQ-031 SHALL check: Alu(R0,0xbbcc) -> never written; Hit=0 on SrcReg=0.
REQ-032 SHALL check: fill to DEPTH-1 -> Full=1; an extra Alu(R5,0x1234) is dropped, Overflow=1, no R5 write ever appears.
REQ-033 SHALL check: queue R8=0x1111 then R8=0xabcd, with SrcReg1=8 -> Hit1=1, PendData1=0xabcd until the second write drains.
REQ-034 SHALL check: rst=0 with 3 entries queued -> next cycle WriteReg=0, Full=0, Overflow=0, and no stale writes follow.
